// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and shift lookup for the HDC encoder binding stage.
package enc_pkg;

  localparam int unsigned DEF_HV_DIM = 1024;
  localparam int unsigned NUM_SHIFTS = 16;
  localparam int unsigned SIDX_W     = $clog2(NUM_SHIFTS);

  // Per-feature bind shifts; features beyond NUM_SHIFTS reuse the table cyclically
  localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
    0, 1, 2, 3, 7, 13, 29, 61, 127, 251, 509, 1021, 17, 97, 389, 769
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIND = 2'd1,
    ST_DONE = 2'd2
  } binder_state_t;

  function automatic int unsigned shift_of(input int unsigned k,
                                           input int unsigned dim = DEF_HV_DIM);
    return SHIFTS[SIDX_W'(k % NUM_SHIFTS)] % dim;
  endfunction

endpackage

// File: rtl/enc_binder_lane.sv
// Combinational variable left-rotator: out[(j+shift) mod HV_DIM] = data[j].
module enc_binder_lane #(
  parameter int unsigned HV_DIM = 1024,
  parameter int unsigned SHW    = (HV_DIM > 1) ? $clog2(HV_DIM) : 1
) (
  input  logic [HV_DIM-1:0] data,
  input  logic [SHW-1:0]    shift,
  output logic [HV_DIM-1:0] rot_c
);

  // Shifting a doubled copy lets the upper half carry the wrapped bits
  always_comb begin
    rot_c = HV_DIM'(({data, data} << shift) >> HV_DIM);
  end

endmodule

// File: rtl/enc_binder_array.sv
// Time-multiplexed binding stage: LANES rotators bind NUM_FEATURES hypervectors over G cycles.
// Optional OR-bundle output enabled by defining ENC_BINDER_BUNDLE_EN.
module enc_binder_array
  import enc_pkg::*;
#(
  parameter int unsigned HV_DIM       = DEF_HV_DIM,
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned LANES        = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hv   [0:NUM_FEATURES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] shifted_hv [0:NUM_FEATURES-1]
`ifdef ENC_BINDER_BUNDLE_EN
  ,
  output logic [HV_DIM-1:0] bundled_hv
`endif
);

  localparam int unsigned G   = (NUM_FEATURES + LANES - 1) / LANES;
  localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned SHW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  binder_state_t     state, state_d;
  logic [GW-1:0]     g;
  logic              accept_c, bind_fire_c, last_grp_c;

  logic [HV_DIM-1:0] in_buf     [NUM_FEATURES];
  logic [HV_DIM-1:0] cand_hv    [LANES][G];
  logic [SHW-1:0]    cand_sh    [LANES][G];
  logic [HV_DIM-1:0] lane_din_c [LANES];
  logic [SHW-1:0]    lane_sh_c  [LANES];
  logic [HV_DIM-1:0] lane_rot_c [LANES];

  // State register plus registered handshake outputs decoded from the next state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
    end
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (in_valid)                  state_d = ST_BIND;
      ST_BIND: if (bind_fire_c && last_grp_c) state_d = ST_DONE;
      ST_DONE: if (out_ready)                 state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // Datapath strobes derived from the current state
  always_comb begin
    accept_c    = 1'b0;
    bind_fire_c = 1'b0;
    last_grp_c  = (g == GW'(G - 1));
    if (!clear) begin
      accept_c    = (state == ST_IDLE) && in_valid;
      bind_fire_c = (state == ST_BIND) && en;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      g <= '0;
    end else if (clear || accept_c) begin
      g <= '0;
    end else if (bind_fire_c) begin
      g <= last_grp_c ? '0 : g + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_buf <= '{default: '0};
    end else if (accept_c) begin
      in_buf <= level_hv;
    end
  end

  // Lane l of group gi serves feature gi*LANES + l; slots past the last feature feed zero
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar gi = 0; gi < G; gi++) begin : g_grp
      localparam int unsigned K = gi * LANES + l;
      if (K < NUM_FEATURES) begin : g_real
        assign cand_hv[l][gi] = in_buf[K];
        assign cand_sh[l][gi] = SHW'(shift_of(K, HV_DIM));
      end else begin : g_pad
        assign cand_hv[l][gi] = '0;
        assign cand_sh[l][gi] = '0;
      end
    end

    assign lane_din_c[l] = cand_hv[l][g];
    assign lane_sh_c[l]  = cand_sh[l][g];

    enc_binder_lane #(
      .HV_DIM (HV_DIM),
      .SHW    (SHW)
    ) u_lane (
      .data  (lane_din_c[l]),
      .shift (lane_sh_c[l]),
      .rot_c (lane_rot_c[l])
    );
  end

  // Each feature register loads only in its own group's cycle
  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
    localparam int unsigned FG = f / LANES;
    localparam int unsigned FL = f % LANES;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        shifted_hv[f] <= '0;
      end else if (bind_fire_c && (g == GW'(FG))) begin
        shifted_hv[f] <= lane_rot_c[FL];
      end
    end
  end

`ifdef ENC_BINDER_BUNDLE_EN
  logic [LANES-1:0]  lane_bits_c [HV_DIM];
  logic [HV_DIM-1:0] lanes_or_c;

  // Bit-transpose the lane results so each output bit is a simple OR-reduction
  for (genvar b = 0; b < HV_DIM; b++) begin : g_bit
    for (genvar l = 0; l < LANES; l++) begin : g_lbit
      assign lane_bits_c[b][l] = lane_rot_c[l][b];
    end
    assign lanes_or_c[b] = |lane_bits_c[b];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bundled_hv <= '0;
    end else if (accept_c) begin
      bundled_hv <= '0;
    end else if (bind_fire_c) begin
      bundled_hv <= bundled_hv | lanes_or_c;
    end
  end
`endif

endmodule

// File: tb/tb_enc_binder_array.sv
// Scoreboard bench for enc_binder_array (HV_DIM=8, NUM_FEATURES=5, LANES=2, G=3).
module tb_enc_binder_array;

  localparam int unsigned HV = 8;
  localparam int unsigned NF = 5;
  localparam int unsigned LN = 2;
  localparam int unsigned GR = 3;
  localparam int unsigned TB_SHIFTS [NF] = '{0, 1, 2, 3, 7};

  logic          clk = 1'b0;
  logic          nrst;
  logic          en;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [HV-1:0] level_hv   [0:NF-1];
  logic          out_valid;
  logic          out_ready;
  logic [HV-1:0] shifted_hv [0:NF-1];
`ifdef ENC_BINDER_BUNDLE_EN
  logic [HV-1:0] bundled_hv;
`endif

  int checks = 0;
  int errors = 0;

  logic [NF*HV-1:0] exp_q  [$];
  logic [HV-1:0]    expb_q [$];
  logic [NF*HV-1:0] last_exp;

  always #5 clk = ~clk;

  enc_binder_array #(
    .HV_DIM       (HV),
    .NUM_FEATURES (NF),
    .LANES        (LN)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .level_hv   (level_hv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .shifted_hv (shifted_hv)
`ifdef ENC_BINDER_BUNDLE_EN
    ,
    .bundled_hv (bundled_hv)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HV-1:0] rotl(input logic [HV-1:0] v, input int unsigned s);
    logic [HV-1:0] r;
    r = '0;
    for (int j = 0; j < int'(HV); j++) r[(j + int'(s)) % int'(HV)] = v[j];
    return r;
  endfunction

  function automatic logic [NF*HV-1:0] got_shifted();
    logic [NF*HV-1:0] p;
    for (int i = 0; i < int'(NF); i++) p[i*HV +: HV] = shifted_hv[i];
    return p;
  endfunction

  task automatic send(input logic [NF*HV-1:0] d);
    logic [NF*HV-1:0] e;
    logic [HV-1:0]    b;
    int               n;
    n = 0;
    b = '0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_ready got in_ready=%b exp 1", in_ready);
    end
    for (int i = 0; i < int'(NF); i++) begin
      level_hv[i]    = d[i*HV +: HV];
      e[i*HV +: HV]  = rotl(d[i*HV +: HV], TB_SHIFTS[i]);
      b             |= e[i*HV +: HV];
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(e);
    expb_q.push_back(b);
  endtask

  task automatic discard();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (expb_q.size() > 0) void'(expb_q.pop_front());
  endtask

  // Wait for out_valid, optionally stalling en, then score the result
  task automatic collect(input string name, input int exp_lat,
                         input int stall_after, input int stall_len);
    logic [HV-1:0] eb;
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (cyc == stall_after) en = 1'b0;
      if (cyc == stall_after + stall_len) en = 1'b1;
      tick();
      cyc++;
    end
    en = 1'b1;
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d", name, cyc, exp_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty exp entry", name);
    end else begin
      last_exp = exp_q.pop_front();
      eb       = expb_q.pop_front();
      if (got_shifted() !== last_exp) begin
        errors++;
        $display("FAIL %s_shifted got %h exp %h", name, got_shifted(), last_exp);
      end
`ifdef ENC_BINDER_BUNDLE_EN
      checks++;
      if (bundled_hv !== eb) begin
        errors++;
        $display("FAIL %s_bundled got %h exp %h", name, bundled_hv, eb);
      end
`endif
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake got in_ready=%b out_valid=%b exp 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if (got_shifted() !== '0) begin
      errors++;
      $display("FAIL reset_shifted got %h exp 0", got_shifted());
    end
`ifdef ENC_BINDER_BUNDLE_EN
    checks++;
    if (bundled_hv !== '0) begin
      errors++;
      $display("FAIL reset_bundled got %h exp 0", bundled_hv);
    end
`endif
  endtask

  task automatic test_basic();
    send({8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    collect("basic", GR, -1, 0);
    checks++;
    if (got_shifted() !== {8'h80, 8'h08, 8'h04, 8'h02, 8'h01}) begin
      errors++;
      $display("FAIL basic_const got %h exp 8008040201", got_shifted());
    end
`ifdef ENC_BINDER_BUNDLE_EN
    checks++;
    if (bundled_hv !== 8'h8F) begin
      errors++;
      $display("FAIL basic_bundle_const got %h exp 8f", bundled_hv);
    end
`endif
    handshake("basic");
  endtask

  task automatic test_wrap();
    send({8'h81, 8'h01, 8'h01, 8'h01, 8'h01});
    collect("wrap", GR, -1, 0);
    checks++;
    if (shifted_hv[4] !== 8'hC0) begin
      errors++;
      $display("FAIL wrap_f4 got %h exp c0", shifted_hv[4]);
    end
    handshake("wrap");
  endtask

  task automatic test_stall();
    send(40'({$urandom(), $urandom()}));
    collect("stall", GR + 2, 1, 2);
    handshake("stall");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(40'({$urandom(), $urandom()}));
    collect("bp", GR, -1, 0);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < int'(NF); i++) level_hv[i] = 8'($urandom());
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_shifted() !== last_exp) begin
        errors++;
        $display("FAIL bp_hold got ov=%b ir=%b data=%h exp 1 0 %h",
                 out_valid, in_ready, got_shifted(), last_exp);
      end
    end
    in_valid = 1'b0;
    handshake("bp");
  endtask

  task automatic test_abort();
    send(40'({$urandom(), $urandom()}));
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    discard();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got ir=%b ov=%b exp 1 0", in_ready, out_valid);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_valid got %b exp 0", out_valid);
      end
    end
    send(40'({$urandom(), $urandom()}));
    collect("post_abort", GR, -1, 0);
    handshake("post_abort");
  endtask

  task automatic test_reset_mid();
    send(40'({$urandom(), $urandom()}));
    tick();
    nrst = 1'b0;
    #1;
    discard();
    test_reset();
    tick();
    nrst = 1'b1;
    tick();
    send(40'({$urandom(), $urandom()}));
    collect("post_reset", GR, -1, 0);
    handshake("post_reset");
  endtask

  initial begin
    nrst      = 1'b0;
    en        = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(NF); i++) level_hv[i] = '0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
